// File: rtl/pwm_hbridge_pkg.sv
// Shared encodings for the H-bridge driver: FSM states, per-leg gate targets,
// and the width of the dead-time counters.
package pwm_hbridge_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_RUN_FWD = 2'd1,
      ST_RUN_REV = 2'd2,
      ST_SWITCH  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      TGT_NONE = 2'd0,
      TGT_HI   = 2'd1,
      TGT_LO   = 2'd2
   } leg_tgt_e;

   function automatic int cnt_width(input int deadtime);
      return (deadtime < 1) ? 1 : $clog2(deadtime + 1);
   endfunction

endpackage

// File: rtl/hbridge_leg.sv
// One half-bridge leg: follows its target, dropping a gate one edge after the
// target moves away and raising a gate only after its complement was low DEADTIME cycles.
module hbridge_leg
   import pwm_hbridge_pkg::*;
#(
   parameter int DEADTIME = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   input  leg_tgt_e tgt,
   output logic     hi,
   output logic     lo
);

   localparam int            CW      = cnt_width(DEADTIME);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEADTIME);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW:0]   DT_W    = (CW + 1)'(DEADTIME);
   localparam logic [CW:0]   ONE_W   = (CW + 1)'(1);

   logic          armed;
   logic [CW-1:0] hi_low_cnt;
   logic [CW-1:0] lo_low_cnt;
   logic          hi_ok;
   logic          lo_ok;
   logic          hi_nxt;
   logic          lo_nxt;

   // The counter covers completed low cycles; the cycle ending at this edge
   // counts too, but only once a full cycle has elapsed since reset release.
   assign hi_ok  = armed && !lo && (({1'b0, lo_low_cnt} + ONE_W) >= DT_W);
   assign lo_ok  = armed && !hi && (({1'b0, hi_low_cnt} + ONE_W) >= DT_W);
   assign hi_nxt = (tgt == TGT_HI) && (hi || hi_ok);
   assign lo_nxt = (tgt == TGT_LO) && (lo || lo_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed      <= 1'b0;
         hi         <= 1'b0;
         lo         <= 1'b0;
         hi_low_cnt <= '0;
         lo_low_cnt <= '0;
      end else begin
         armed <= 1'b1;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         if (hi)
            hi_low_cnt <= '0;
         else if (armed && (hi_low_cnt != CNT_MAX))
            hi_low_cnt <= hi_low_cnt + CNT_ONE;
         if (lo)
            lo_low_cnt <= '0;
         else if (armed && (lo_low_cnt != CNT_MAX))
            lo_low_cnt <= lo_low_cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/pwm_hbridge_driver.sv
// Sign-magnitude H-bridge gate driver: registered pwm/dir/en feed a 4-state FSM whose
// next state selects the leg targets; gates are registered inside the legs.
module pwm_hbridge_driver
   import pwm_hbridge_pkg::*;
#(
   parameter int DEADTIME         = 8,
   parameter bit BRAKE_ON_DISABLE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm,
   input  logic dir,
   input  logic en,
   output logic hi_a,
   output logic lo_a,
   output logic hi_b,
   output logic lo_b,
   output logic active
);

   localparam int            CW      = cnt_width(DEADTIME);
   localparam logic [CW-1:0] SW_LAST = CW'(DEADTIME - 1);
   localparam logic [CW-1:0] SW_ONE  = CW'(1);

   logic          pwm_r;
   logic          dir_r;
   logic          en_r;
   state_e        state;
   state_e        state_nxt;
   logic [CW-1:0] sw_cnt;
   logic          sw_dir;
   logic          sw_restart;
   leg_tgt_e      tgt_a;
   leg_tgt_e      tgt_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_r <= 1'b0;
         dir_r <= 1'b0;
         en_r  <= 1'b0;
         state <= ST_OFF;
      end else begin
         pwm_r <= pwm;
         dir_r <= dir;
         en_r  <= en;
         state <= state_nxt;
      end
   end

   // Targets follow the next state so gates react one edge after an input is sampled.
   always_comb begin
      state_nxt  = state;
      sw_restart = 1'b0;
      tgt_a      = TGT_NONE;
      tgt_b      = TGT_NONE;

      case (state)
         ST_OFF: begin
            if (en_r)
               state_nxt = dir_r ? ST_RUN_FWD : ST_RUN_REV;
         end
         ST_RUN_FWD: begin
            if (!en_r) begin
               state_nxt = ST_OFF;
            end else if (!dir_r) begin
               state_nxt  = ST_SWITCH;
               sw_restart = 1'b1;
            end
         end
         ST_RUN_REV: begin
            if (!en_r) begin
               state_nxt = ST_OFF;
            end else if (dir_r) begin
               state_nxt  = ST_SWITCH;
               sw_restart = 1'b1;
            end
         end
         ST_SWITCH: begin
            if (!en_r)
               state_nxt = ST_OFF;
            else if (dir_r != sw_dir)
               sw_restart = 1'b1;
            else if (sw_cnt == SW_LAST)
               state_nxt = dir_r ? ST_RUN_FWD : ST_RUN_REV;
         end
         default: state_nxt = ST_OFF;
      endcase

      case (state_nxt)
         ST_OFF: begin
            if (BRAKE_ON_DISABLE) begin
               tgt_a = TGT_LO;
               tgt_b = TGT_LO;
            end
         end
         ST_RUN_FWD: begin
            tgt_a = pwm_r ? TGT_HI : TGT_LO;
            tgt_b = TGT_LO;
         end
         ST_RUN_REV: begin
            tgt_a = TGT_LO;
            tgt_b = pwm_r ? TGT_HI : TGT_LO;
         end
         default: begin
            tgt_a = TGT_NONE;
            tgt_b = TGT_NONE;
         end
      endcase
   end

   // All-off interval length; a direction flip while switching starts it over.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_cnt <= '0;
         sw_dir <= 1'b0;
      end else if (sw_restart) begin
         sw_cnt <= '0;
         sw_dir <= dir_r;
      end else if ((state == ST_SWITCH) && (sw_cnt != SW_LAST)) begin
         sw_cnt <= sw_cnt + SW_ONE;
      end
   end

   assign active = (state == ST_RUN_FWD) || (state == ST_RUN_REV);

   hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .tgt   (tgt_a),
      .hi    (hi_a),
      .lo    (lo_a)
   );

   hbridge_leg #(.DEADTIME(DEADTIME)) u_leg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .tgt   (tgt_b),
      .hi    (hi_b),
      .lo    (lo_b)
   );

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Directed checks on coast/brake drivers with DEADTIME=4, then a randomized
// overlap/dead-time property run across DEADTIME 4, 4, 1 and 8.
module tb_pwm_hbridge_driver;

   logic clk = 1'b0;
   logic rst_n;
   logic pwm;
   logic dir;
   logic en;
   logic hi_a_v   [4];
   logic lo_a_v   [4];
   logic hi_b_v   [4];
   logic lo_b_v   [4];
   logic active_v [4];
   int   dt_v     [4] = '{4, 4, 1, 8};
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   pwm_hbridge_driver #(.DEADTIME(4), .BRAKE_ON_DISABLE(1'b0)) dut_coast (
      .clk(clk), .rst_n(rst_n), .pwm(pwm), .dir(dir), .en(en),
      .hi_a(hi_a_v[0]), .lo_a(lo_a_v[0]), .hi_b(hi_b_v[0]), .lo_b(lo_b_v[0]),
      .active(active_v[0]));

   pwm_hbridge_driver #(.DEADTIME(4), .BRAKE_ON_DISABLE(1'b1)) dut_brake (
      .clk(clk), .rst_n(rst_n), .pwm(pwm), .dir(dir), .en(en),
      .hi_a(hi_a_v[1]), .lo_a(lo_a_v[1]), .hi_b(hi_b_v[1]), .lo_b(lo_b_v[1]),
      .active(active_v[1]));

   pwm_hbridge_driver #(.DEADTIME(1), .BRAKE_ON_DISABLE(1'b1)) dut_dt1 (
      .clk(clk), .rst_n(rst_n), .pwm(pwm), .dir(dir), .en(en),
      .hi_a(hi_a_v[2]), .lo_a(lo_a_v[2]), .hi_b(hi_b_v[2]), .lo_b(lo_b_v[2]),
      .active(active_v[2]));

   pwm_hbridge_driver #(.DEADTIME(8), .BRAKE_ON_DISABLE(1'b0)) dut_dt8 (
      .clk(clk), .rst_n(rst_n), .pwm(pwm), .dir(dir), .en(en),
      .hi_a(hi_a_v[3]), .lo_a(lo_a_v[3]), .hi_b(hi_b_v[3]), .lo_b(lo_b_v[3]),
      .active(active_v[3]));

   // {hi_a, lo_a, hi_b, lo_b}
   function automatic logic [3:0] gates(input int i);
      return {hi_a_v[i], lo_a_v[i], hi_b_v[i], lo_b_v[i]};
   endfunction

   // {brake gates, coast gates, brake active, coast active}
   function automatic logic [9:0] obs();
      return {gates(1), gates(0), active_v[1], active_v[0]};
   endfunction

   task automatic tick(input int n = 1);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic test_reset();
      logic [3:0] eg;
      logic       ea;
      rst_n = 1'b0; pwm = 1'b0; dir = 1'b1; en = 1'b1;
      tick(2);
      n_total++;
      if (obs() !== 10'b0) $display("FAIL reset_hold got %b want %b", obs(), 10'b0);
      else n_pass++;
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         eg = (k >= 5) ? 4'b0101 : 4'b0000;
         ea = (k >= 2);
         n_total++;
         if (obs() !== {eg, eg, ea, ea})
            $display("FAIL reset_release k=%0d got %b want %b", k, obs(), {eg, eg, ea, ea});
         else n_pass++;
      end
   endtask

   task automatic test_pwm_edges();
      logic [3:0] eg;
      tick(2);
      pwm = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         eg = (k == 1) ? 4'b0101 : (k < 6) ? 4'b0001 : 4'b1001;
         n_total++;
         if (obs() !== {eg, eg, 2'b11})
            $display("FAIL pwm_rise k=%0d got %b want %b", k, obs(), {eg, eg, 2'b11});
         else n_pass++;
      end
      pwm = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         eg = (k == 1) ? 4'b1001 : (k < 6) ? 4'b0001 : 4'b0101;
         n_total++;
         if (obs() !== {eg, eg, 2'b11})
            $display("FAIL pwm_fall k=%0d got %b want %b", k, obs(), {eg, eg, 2'b11});
         else n_pass++;
      end
   endtask

   task automatic test_short_pulse();
      logic [3:0] eg;
      tick(2);
      pwm = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         eg = (k == 2 || k == 3) ? 4'b0001 : 4'b0101;
         n_total++;
         if (obs() !== {eg, eg, 2'b11})
            $display("FAIL short_pulse k=%0d got %b want %b", k, obs(), {eg, eg, 2'b11});
         else n_pass++;
         if (k == 2) pwm = 1'b0;
      end
   endtask

   task automatic test_switch();
      logic [3:0] eg;
      logic [1:0] ea;
      tick(2);
      dir = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         eg = (k == 1 || k == 6) ? 4'b0101 : 4'b0000;
         ea = (k == 1 || k == 6) ? 2'b11 : 2'b00;
         n_total++;
         if (obs() !== {eg, eg, ea})
            $display("FAIL switch_rev k=%0d got %b want %b", k, obs(), {eg, eg, ea});
         else n_pass++;
      end
      pwm = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         eg = (k == 1) ? 4'b0101 : (k < 6) ? 4'b0100 : 4'b0110;
         n_total++;
         if (obs() !== {eg, eg, 2'b11})
            $display("FAIL rev_leg_b k=%0d got %b want %b", k, obs(), {eg, eg, 2'b11});
         else n_pass++;
      end
      dir = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         eg = (k == 1 || k == 8) ? 4'b0110 : 4'b0000;
         ea = (k == 1 || k == 8) ? 2'b11 : 2'b00;
         n_total++;
         if (obs() !== {eg, eg, ea})
            $display("FAIL switch_restart k=%0d got %b want %b", k, obs(), {eg, eg, ea});
         else n_pass++;
         if (k == 2) dir = 1'b0;
      end
   endtask

   // Disable from RUN_FWD with hi_a on; optionally flip dir in the same cycle.
   task automatic test_disable(input logic with_dir);
      logic [3:0] eb;
      logic [3:0] ec;
      logic [1:0] ea;
      en = 1'b1; dir = 1'b1; pwm = 1'b1;
      tick(12);
      en = 1'b0;
      if (with_dir) dir = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         ec = (k == 1) ? 4'b1001 : 4'b0000;
         eb = (k == 1) ? 4'b1001 : (k < 6) ? 4'b0001 : 4'b0101;
         ea = (k == 1) ? 2'b11 : 2'b00;
         n_total++;
         if (obs() !== {eb, ec, ea})
            $display("FAIL disable%0d k=%0d got %b want %b", with_dir, k, obs(), {eb, ec, ea});
         else n_pass++;
      end
   endtask

   task automatic test_reenable();
      logic [3:0] ec;
      logic [1:0] ea;
      tick(2);
      en = 1'b1; dir = 1'b0; pwm = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         ec = (k == 1) ? 4'b0000 : 4'b0101;
         ea = (k == 1) ? 2'b00 : 2'b11;
         n_total++;
         if (obs() !== {4'b0101, ec, ea})
            $display("FAIL reenable k=%0d got %b want %b", k, obs(), {4'b0101, ec, ea});
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int   hcnt [4][2];
      int   lcnt [4][2];
      logic ph   [4][2];
      logic pl   [4][2];
      logic h;
      logic l;
      int   flip;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 2; j++) begin
            hcnt[i][j] = 0; lcnt[i][j] = 0; ph[i][j] = 1'b0; pl[i][j] = 1'b0;
         end
      rst_n = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 2; j++) begin
               h = (j == 0) ? hi_a_v[i] : hi_b_v[i];
               l = (j == 0) ? lo_a_v[i] : lo_b_v[i];
               n_total++;
               if (h === 1'b1 && l === 1'b1)
                  $display("FAIL overlap dut=%0d leg=%0d cyc=%0d hi=%b lo=%b want not both", i, j, cyc, h, l);
               else n_pass++;
               if (!rst_n) begin
                  hcnt[i][j] = 0; lcnt[i][j] = 0; ph[i][j] = 1'b0; pl[i][j] = 1'b0;
               end else begin
                  if (h && !ph[i][j]) begin
                     n_total++;
                     if (lcnt[i][j] < dt_v[i])
                        $display("FAIL deadtime_hi dut=%0d leg=%0d cyc=%0d low=%0d need %0d", i, j, cyc, lcnt[i][j], dt_v[i]);
                     else n_pass++;
                  end
                  if (l && !pl[i][j]) begin
                     n_total++;
                     if (hcnt[i][j] < dt_v[i])
                        $display("FAIL deadtime_lo dut=%0d leg=%0d cyc=%0d low=%0d need %0d", i, j, cyc, hcnt[i][j], dt_v[i]);
                     else n_pass++;
                  end
                  hcnt[i][j] = h ? 0 : ((hcnt[i][j] < 100) ? hcnt[i][j] + 1 : 100);
                  lcnt[i][j] = l ? 0 : ((lcnt[i][j] < 100) ? lcnt[i][j] + 1 : 100);
                  ph[i][j] = h;
                  pl[i][j] = l;
               end
            end
         end
         if (!rst_n) begin
            if ($urandom_range(0, 2) == 0) rst_n = 1'b1;
         end else if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
         end
         flip = 2 + ((cyc / 500) % 4) * 6;
         if ($urandom_range(0, flip - 1) == 0) pwm = ~pwm;
         if ($urandom_range(0, 49) == 0) dir = ~dir;
         if ($urandom_range(0, 79) == 0) en = ~en;
      end
   endtask

   initial begin
      test_reset();
      test_pwm_edges();
      test_short_pulse();
      test_switch();
      test_disable(1'b0);
      test_disable(1'b1);
      test_reenable();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
